// File: rtl/ahb_bram_bridge.sv
// AHB-Lite slave bridging single-cycle AHB transfers onto a simple-dual-port block RAM.
// Define AHB_BRAM_FWD_EN to forward write data on a same-word read hazard instead of inserting a wait state.
module ahb_bram_bridge #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);
    typedef enum logic [0:0] {NORMAL = 1'b0, STALL = 1'b1} state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << offs;
            3'd1:    mask = offs[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    state_t                  state_r;
    logic                    wr_pend_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [3:0]              wr_be_r;
    logic                    rd_pend_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic                    hreadyout_r;
`ifdef AHB_BRAM_FWD_EN
    logic [3:0]              fwd_be_r;
    logic [31:0]             fwd_data_r;
`endif

    logic                    accept_s;
    logic                    hazard_s;
    logic [ADDR_WIDTH-1:0]   haddr_word_s;
    logic [31:0]             rdata_s;
    logic                    unused_s;

    assign haddr_word_s = HADDR[ADDR_WIDTH+1:2];
    assign accept_s     = HSEL & HREADY & HTRANS[1] & (state_r == NORMAL);
    // A read landing on the word being written this very cycle would see stale RAM data.
    assign hazard_s     = accept_s & ~HWRITE & wr_pend_r & (wr_addr_r == haddr_word_s);
    assign unused_s     = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // Transfer tracking, hazard state machine and wait-state generation.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r     <= NORMAL;
            wr_pend_r   <= 1'b0;
            wr_addr_r   <= '0;
            wr_be_r     <= 4'b0000;
            rd_pend_r   <= 1'b0;
            rd_addr_r   <= '0;
            hreadyout_r <= 1'b1;
`ifdef AHB_BRAM_FWD_EN
            fwd_be_r    <= 4'b0000;
            fwd_data_r  <= 32'h0000_0000;
`endif
        end else begin
            case (state_r)
                NORMAL: begin
                    wr_pend_r <= accept_s & HWRITE;
                    rd_pend_r <= accept_s & ~HWRITE;
                    if (accept_s && HWRITE) begin
                        wr_addr_r <= haddr_word_s;
                        wr_be_r   <= lane_mask(HSIZE, HADDR[1:0]);
                    end
                    if (accept_s && !HWRITE) begin
                        rd_addr_r <= haddr_word_s;
                    end
`ifdef AHB_BRAM_FWD_EN
                    fwd_be_r    <= hazard_s ? wr_be_r : 4'b0000;
                    fwd_data_r  <= hazard_s ? HWDATA : 32'h0000_0000;
                    hreadyout_r <= 1'b1;
                    state_r     <= NORMAL;
`else
                    hreadyout_r <= ~hazard_s;
                    state_r     <= hazard_s ? STALL : NORMAL;
`endif
                end
                STALL: begin
                    // The read stays pending; RAM re-reads rd_addr after the write has landed.
                    wr_pend_r   <= 1'b0;
                    hreadyout_r <= 1'b1;
                    state_r     <= NORMAL;
                end
                default: begin
                    wr_pend_r   <= 1'b0;
                    rd_pend_r   <= 1'b0;
                    hreadyout_r <= 1'b1;
                    state_r     <= NORMAL;
                end
            endcase
        end
    end

    // Read data selection: optional byte-wise merge of forwarded write data.
    always_comb begin
        rdata_s = bram_doutb;
`ifdef AHB_BRAM_FWD_EN
        for (int b = 0; b < 4; b++) begin
            if (fwd_be_r[b]) begin
                rdata_s[8*b +: 8] = fwd_data_r[8*b +: 8];
            end else begin
                rdata_s[8*b +: 8] = bram_doutb[8*b +: 8];
            end
        end
`endif
        if (rd_pend_r && hreadyout_r) begin
            HRDATA = rdata_s;
        end else begin
            HRDATA = 32'h0000_0000;
        end
    end

    assign HREADYOUT  = hreadyout_r;
    assign HRESP      = 1'b0;
    assign bram_addra = wr_addr_r;
    assign bram_dina  = HWDATA;
    assign bram_wea   = wr_pend_r ? wr_be_r : 4'b0000;
    assign bram_addrb = (state_r == STALL) ? rd_addr_r : haddr_word_s;

endmodule
